// File: rtl/dac_pkg.sv
// Shared types for the DAC bus arbiter: FSM states, DAC channel and code types, and the latched request record.
// Combinational-only package; no latency and no flow control of its own.
package dac_pkg;

    localparam int DAC_NUM_CHAN = 4;

    typedef logic [1:0] dac_chan_t;
    typedef logic [7:0] dac_code_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        LDAC
    } dac_state_t;

    typedef struct packed {
        dac_chan_t chan;
        dac_code_t code;
        logic      ldac;
    } dac_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant among N requesters: the first active request at or after the pointer wins, with wrap-around.
// Grant is combinational (zero latency); the pointer moves past the winner only when enable is high and a grant exists.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          enable,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr;
    logic          found;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found   = 1'b1;
                gnt_idx = IW'((int'(ptr) + i) % N);
            end
        end
        gnt = found ? (N'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (enable && found) begin
            ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

endmodule

// File: rtl/dac_bus_arbiter.sv
// Shares one quad 8-bit parallel DAC among N_REQ requesters; each grant becomes a 3*CLK_DIV write cycle (+CLK_DIV LDAC).
// req_ready strobes only in IDLE so requests wait while busy; DAC_SHADOW_EN adds a shadow port and skips redundant writes.
module dac_bus_arbiter
    import dac_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dac_enable,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [2*N_REQ-1:0]   req_chan,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_ldac,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 busy,
    output dac_code_t            db,
    output dac_chan_t            A,
    output logic                 cs_n,
    output logic                 wr_n,
    output logic                 ldac_n,
    output logic                 clr_n,
`ifdef DAC_SHADOW_EN
    output logic [8*DAC_NUM_CHAN-1:0] shadow,
`endif
    output logic                 pd_n
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    dac_state_t       state;
    dac_state_t       nxt;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gidx;
    logic             in_idle;
    logic             phase_done;
    logic             skip;
    logic             accept;
    dac_req_t         sel;
    dac_req_t         lat;

    assign in_idle    = (state == IDLE);
    assign busy       = !in_idle;
    assign pd_n       = 1'b1;
    assign phase_done = (cnt == CNT_W'(CLK_DIV - 1));
    assign req_ready  = in_idle ? gnt : '0;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .enable  (in_idle),
        .gnt     (gnt),
        .gnt_idx (gidx)
    );

    always_comb begin
        sel.chan = req_chan[2*int'(gidx) +: 2];
        sel.code = req_data[8*int'(gidx) +: 8];
        sel.ldac = req_ldac[gidx];
    end

`ifdef DAC_SHADOW_EN
    // A write that would not change the DAC and needs no LDAC is acknowledged but never reaches the bus.
    assign skip = !sel.ldac && (shadow[8*int'(sel.chan) +: 8] == sel.code);
`else
    assign skip = 1'b0;
`endif

    assign accept = in_idle && (|gnt) && !skip;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept)     nxt = SETUP;
            SETUP:   if (phase_done) nxt = STROBE;
            STROBE:  if (phase_done) nxt = HOLD;
            HOLD:    if (phase_done) nxt = lat.ldac ? LDAC : IDLE;
            LDAC:    if (phase_done) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            lat   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state || in_idle) ? '0 : cnt + CNT_W'(1);
            if (accept) begin
                lat <= sel;
            end
        end
    end

    // Strobes are decoded from the next state so the pins change on the same edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db     <= '0;
            A      <= '0;
            cs_n   <= 1'b1;
            wr_n   <= 1'b1;
            ldac_n <= 1'b1;
            clr_n  <= 1'b0;
        end else begin
            clr_n  <= dac_enable;
            cs_n   <= !(nxt == SETUP || nxt == STROBE || nxt == HOLD);
            wr_n   <= (nxt != STROBE);
            ldac_n <= (nxt != LDAC);
            if (accept) begin
                A  <= sel.chan;
                db <= sel.code;
            end
        end
    end

`ifdef DAC_SHADOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (state == HOLD) begin
            shadow[8*int'(lat.chan) +: 8] <= lat.code;
        end
    end
`endif

endmodule

// File: tb/tb_dac_bus_arbiter.sv
// Bench for dac_bus_arbiter: a timeline model (position since grant) checked every cycle plus directed literal checks.
module tb_dac_bus_arbiter;

    localparam int N = 4;
    localparam int D = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             dac_enable = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [2*N-1:0]   req_chan = '0;
    logic [8*N-1:0]   req_data = '0;
    logic [N-1:0]     req_ldac = '0;
    logic [N-1:0]     req_ready;
    logic             busy;
    logic [7:0]       db;
    logic [1:0]       A;
    logic             cs_n, wr_n, ldac_n, clr_n, pd_n;
`ifdef DAC_SHADOW_EN
    logic [31:0]      shadow;
`endif

    dac_bus_arbiter #(.N_REQ(N), .CLK_DIV(D), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dac_enable (dac_enable),
        .req_valid  (req_valid),
        .req_chan   (req_chan),
        .req_data   (req_data),
        .req_ldac   (req_ldac),
        .req_ready  (req_ready),
        .busy       (busy),
        .db         (db),
        .A          (A),
        .cs_n       (cs_n),
        .wr_n       (wr_n),
        .ldac_n     (ldac_n),
        .clr_n      (clr_n),
`ifdef DAC_SHADOW_EN
        .shadow     (shadow),
`endif
        .pd_n       (pd_n)
    );

    always #4 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: pos = cycles since the grant edge (0 = idle); a write occupies pos 1..3D, LDAC pos 3D+1..4D.
    int         pos = 0;
    int         len = 0;
    int         ptr = 0;
    int         m_g;
    logic [N-1:0] m_rdy;
    logic       m_skip;
    logic [1:0] m_A, c_ch;
    logic [7:0] m_db, c_d;
    logic       m_clr, c_ld;
    logic [7:0] m_sh [4];
    logic [1:0] m_ch;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_cs_n", cs_n, 1);
            chk("rst_wr_n", wr_n, 1);
            chk("rst_ldac_n", ldac_n, 1);
            chk("rst_clr_n", clr_n, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_db", db, 0);
            chk("rst_A", A, 0);
            pos = 0; len = 0; ptr = 0; m_A = 0; m_db = 0; m_clr = dac_enable;
            for (int k = 0; k < 4; k++) m_sh[k] = 8'h00;
        end else begin
            m_rdy = '0;
            m_g   = -1;
            if (pos == 0) begin
                for (int i = 0; i < N; i++)
                    if (m_g < 0 && req_valid[(ptr + i) % N]) m_g = (ptr + i) % N;
                if (m_g >= 0) m_rdy[m_g] = 1'b1;
            end
            chk("cs_n", cs_n, !(pos >= 1 && pos <= 3*D));
            chk("wr_n", wr_n, !(pos >= D+1 && pos <= 2*D));
            chk("ldac_n", ldac_n, !(pos > 3*D));
            chk("busy", busy, pos != 0);
            chk("req_ready", req_ready, m_rdy);
            chk("A", A, m_A);
            chk("db", db, m_db);
            chk("clr_n", clr_n, m_clr);
            chk("pd_n", pd_n, 1);
`ifdef DAC_SHADOW_EN
            chk("shadow", shadow, {m_sh[3], m_sh[2], m_sh[1], m_sh[0]});
`endif
            m_clr = dac_enable;
            if (pos == 0) begin
                if (m_g >= 0) begin
                    c_ch = req_chan[2*m_g +: 2];
                    c_d  = req_data[8*m_g +: 8];
                    c_ld = req_ldac[m_g];
                    ptr  = (m_g + 1) % N;
`ifdef DAC_SHADOW_EN
                    m_skip = (m_sh[c_ch] == c_d) && !c_ld;
`else
                    m_skip = 1'b0;
`endif
                    if (!m_skip) begin
                        pos = 1; m_A = c_ch; m_db = c_d; m_ch = c_ch;
                        len = c_ld ? 4*D : 3*D;
                    end
                end
            end else begin
                if (pos == 2*D+1) m_sh[m_ch] = m_db;
                pos = (pos == len) ? 0 : pos + 1;
            end
        end
    end

    task automatic drive_req(input int i, input logic [1:0] ch, input logic [7:0] d, input logic ld);
        req_valid[i]      = 1'b1;
        req_chan[2*i +: 2] = ch;
        req_data[8*i +: 8] = d;
        req_ldac[i]       = ld;
    endtask

    task automatic wait_ready(input int i, input string name, output int t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if ((|req_ready) && !req_ready[i]) chk({name, "_order"}, req_ready, 32'(1) << i);
        end while (!req_ready[i] && n < 200);
        if (!req_ready[i]) chk({name, "_timeout"}, req_ready[i], 1);
        else chk(name, req_ready, 32'(1) << i);
        t = cyc;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        if (busy) chk({name, "_idle_timeout"}, busy, 0);
    endtask

    task automatic measure(input int ncyc, output int cs_lo, output int wr_first, output int wr_last,
                           output int ld_lo, output int bsy, output int rdy);
        cs_lo = 0; wr_first = 0; wr_last = 0; ld_lo = 0; bsy = 0; rdy = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (!cs_n) cs_lo++;
            if (!wr_n) begin
                if (wr_first == 0) wr_first = k;
                wr_last = k;
            end
            if (!ldac_n) ld_lo++;
            if (busy) bsy++;
            if (|req_ready) rdy++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, tprev, cs_lo, wf, wl, ld_lo, bsy, rdy;

        // Reset values while rst_n is low
        repeat (2) @(negedge clk);
        chk("init_cs_n", cs_n, 1);
        chk("init_clr_n", clr_n, 0);
        chk("init_busy", busy, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("clr_follows_enable", clr_n, 1);

        // Single write, no LDAC
        @(posedge clk) #1 drive_req(0, 2'd2, 8'hA5, 1'b0);
        wait_ready(0, "t1_grant", t);
        @(posedge clk) #1 req_valid[0] = 1'b0;
        measure(14, cs_lo, wf, wl, ld_lo, bsy, rdy);
        chk("t1_cs_low_cycles", cs_lo, 12);
        chk("t1_wr_first", wf, 5);
        chk("t1_wr_last", wl, 8);
        chk("t1_ldac_low", ld_lo, 0);
        chk("t1_busy_cycles", bsy, 12);
        chk("t1_extra_ready", rdy, 0);
        chk("t1_A", A, 2);
        chk("t1_db", db, 8'hA5);

        // Write with LDAC; dac_enable toggles mid-cycle
        @(posedge clk) #1 drive_req(1, 2'd3, 8'h3C, 1'b1);
        wait_ready(1, "t2_grant", t);
        @(posedge clk) #1 req_valid[1] = 1'b0;
        fork
            measure(18, cs_lo, wf, wl, ld_lo, bsy, rdy);
            begin
                repeat (6) @(posedge clk);
                #1 dac_enable = 1'b0;
                repeat (3) @(posedge clk);
                #1 dac_enable = 1'b1;
            end
        join
        chk("t2_busy_cycles", bsy, 16);
        chk("t2_ldac_low", ld_lo, 4);
        chk("t2_cs_low_cycles", cs_lo, 12);
        chk("t2_wr_first", wf, 5);
        chk("t2_db", db, 8'h3C);

        // Asynchronous reset in the middle of STROBE
        @(posedge clk) #1 drive_req(2, 2'd1, 8'h77, 1'b0);
        wait_ready(2, "t3_grant", t);
        @(posedge clk) #1 req_valid[2] = 1'b0;
        repeat (6) @(negedge clk);
        chk("t3_in_strobe", wr_n, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t3_async_wr_n", wr_n, 1);
        chk("t3_async_cs_n", cs_n, 1);
        chk("t3_async_ldac_n", ldac_n, 1);
        chk("t3_async_clr_n", clr_n, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t3_post_busy", busy, 0);

        // All requesters valid: strict round robin from pointer 0
        @(posedge clk) #1;
        for (int i = 0; i < N; i++) drive_req(i, 2'(i), 8'(8'h11 * (i + 1)), 1'b0);
        tprev = 0;
        for (int j = 0; j < 5; j++) begin
            wait_ready(j % N, "t4_rr_grant", t);
            if (j > 0) chk("t4_spacing", t - tprev, 13);
            tprev = t;
        end
        @(posedge clk) #1 req_valid = '0;
        // A request withdrawn before acceptance is simply dropped
        repeat (3) @(posedge clk);
        #1 drive_req(3, 2'd0, 8'hEE, 1'b0);
        repeat (2) @(posedge clk);
        #1 req_valid[3] = 1'b0;
        wait_idle("t4");
        measure(4, cs_lo, wf, wl, ld_lo, bsy, rdy);
        chk("t4_dropped_req", rdy, 0);

        // Pointer wrap: grant 2 moves the pointer to 3, then 1 and 3 compete
        @(posedge clk) #1 drive_req(2, 2'd2, 8'h42, 1'b0);
        wait_ready(2, "t5_setup_grant", t);
        @(posedge clk) #1 req_valid[2] = 1'b0;
        wait_idle("t5a");
        @(posedge clk) #1;
        drive_req(1, 2'd1, 8'h5A, 1'b0);
        drive_req(3, 2'd3, 8'hC3, 1'b0);
        wait_ready(3, "t5_wrap_first", t);
        @(posedge clk) #1 req_valid[3] = 1'b0;
        wait_ready(1, "t5_wrap_second", t);
        @(posedge clk) #1 req_valid[1] = 1'b0;
        wait_idle("t5b");

`ifdef DAC_SHADOW_EN
        @(posedge clk) #1 drive_req(0, 2'd0, 8'h10, 1'b0);
        wait_ready(0, "t6_first", t);
        @(posedge clk) #1 req_valid[0] = 1'b0;
        wait_idle("t6a");
        chk("t6_shadow_ch0", shadow[7:0], 8'h10);
        @(posedge clk) #1 drive_req(0, 2'd0, 8'h10, 1'b0);
        wait_ready(0, "t6_repeat", t);
        @(posedge clk) #1 req_valid[0] = 1'b0;
        measure(6, cs_lo, wf, wl, ld_lo, bsy, rdy);
        chk("t6_skip_cs", cs_lo, 0);
        chk("t6_skip_busy", bsy, 0);
        @(posedge clk) #1 drive_req(0, 2'd0, 8'h10, 1'b1);
        wait_ready(0, "t6_repeat_ldac", t);
        @(posedge clk) #1 req_valid[0] = 1'b0;
        measure(18, cs_lo, wf, wl, ld_lo, bsy, rdy);
        chk("t6_ldac_busy", bsy, 16);
        chk("t6_ldac_low", ld_lo, 4);
        chk("t6_ldac_cs", cs_lo, 12);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
